// File: rtl/battle_pkg.sv
// Shared battle constants: state encoding seen by the renderer, default HP and
// damage values, and the saturating subtract used by the HP counters.
package battle_pkg;

  localparam int unsigned HP_W = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MENU    = 3'd1;
  localparam logic [2:0] ST_ATK_ARM = 3'd2;
  localparam logic [2:0] ST_ATK_RUN = 3'd3;
  localparam logic [2:0] ST_APPLY   = 3'd4;
  localparam logic [2:0] ST_DODGE   = 3'd5;
  localparam logic [2:0] ST_WIN     = 3'd6;
  localparam logic [2:0] ST_LOSE    = 3'd7;

  localparam logic [HP_W-1:0] ENEMY_HP_DEFAULT     = 8'd100;
  localparam logic [HP_W-1:0] PLAYER_HP_DEFAULT    = 8'd20;
  localparam logic [HP_W-1:0] HIT_DMG_DEFAULT      = 8'd4;
  localparam logic [15:0]     DODGE_CYCLES_DEFAULT = 16'd1000;

  // Borrow out of the 9-bit difference means the result would go negative.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                              input logic [HP_W-1:0] b);
    logic [HP_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[HP_W] ? '0 : diff[HP_W-1:0];
  endfunction

endpackage

// File: rtl/battle_hp_counter.sv
// HP register with load-to-initial, saturating decrement and a flag telling
// whether the value written at the coming edge will be zero.
module battle_hp_counter
  import battle_pkg::*;
#(
  parameter logic [HP_W-1:0] INIT = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            dec,
  input  logic [HP_W-1:0] amount,
  output logic [HP_W-1:0] value,
  output logic            zero_next
);

  logic [HP_W-1:0] value_next;

  always_comb begin
    value_next = value;
    if (load)
      value_next = INIT;
    else if (dec)
      value_next = sat_sub(value, amount);
  end

  assign zero_next = (value_next == '0);

  always_ff @(posedge clk) begin
    if (reset)
      value <= INIT;
    else
      value <= value_next;
  end

endmodule

// File: rtl/battle_sequencer.sv
// Turn sequencer for the battle screen: menu, attack gauge, damage apply,
// timed dodge phase and win/lose terminal states.
module battle_sequencer
  import battle_pkg::*;
#(
  parameter logic [HP_W-1:0] ENEMY_HP_INIT  = ENEMY_HP_DEFAULT,
  parameter logic [HP_W-1:0] PLAYER_HP_INIT = PLAYER_HP_DEFAULT,
  parameter logic [HP_W-1:0] HIT_DMG        = HIT_DMG_DEFAULT,
  parameter logic [15:0]     DODGE_CYCLES   = DODGE_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_game,
  input  logic            act_btn,
  input  logic            atk_pass,
  input  logic [HP_W-1:0] atk_damage,
  input  logic            player_hit,
  output logic            atk_reset,
  output logic            atk_start,
  output logic            dodge_en,
  output logic [HP_W-1:0] enemy_hp,
  output logic [HP_W-1:0] player_hp,
  output logic [2:0]      phase,
  output logic            win,
  output logic            lose
);

  localparam logic [15:0] DODGE_LAST = DODGE_CYCLES - 16'd1;

  logic [2:0]      state;
  logic [2:0]      state_next;
  logic [HP_W-1:0] dmg;
  logic [15:0]     dodge_cnt;
  logic            hp_load;
  logic            enemy_dec;
  logic            player_dec;
  logic            enemy_zero_next;
  logic            player_zero_next;

  assign phase = state;

  battle_hp_counter #(.INIT(ENEMY_HP_INIT)) u_enemy_hp (
    .clk       (clk),
    .reset     (reset),
    .load      (hp_load),
    .dec       (enemy_dec),
    .amount    (dmg),
    .value     (enemy_hp),
    .zero_next (enemy_zero_next)
  );

  battle_hp_counter #(.INIT(PLAYER_HP_INIT)) u_player_hp (
    .clk       (clk),
    .reset     (reset),
    .load      (hp_load),
    .dec       (player_dec),
    .amount    (HIT_DMG),
    .value     (player_hp),
    .zero_next (player_zero_next)
  );

  always_comb begin
    state_next = state;
    hp_load    = 1'b0;
    enemy_dec  = 1'b0;
    player_dec = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_game) begin
          state_next = ST_MENU;
          hp_load    = 1'b1;
        end
      end
      ST_MENU:    if (act_btn) state_next = ST_ATK_ARM;
      ST_ATK_ARM: state_next = ST_ATK_RUN;
      ST_ATK_RUN: if (atk_pass) state_next = ST_APPLY;
      ST_APPLY: begin
        enemy_dec  = 1'b1;
        state_next = enemy_zero_next ? ST_WIN : ST_DODGE;
      end
      ST_DODGE: begin
        // Hit lands before expiry is considered, so a fatal last-cycle hit loses.
        player_dec = player_hit;
        if (player_zero_next)
          state_next = ST_LOSE;
        else if (dodge_cnt == DODGE_LAST)
          state_next = ST_MENU;
      end
      ST_WIN, ST_LOSE: if (start_game) state_next = ST_IDLE;
      default:         state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dmg       <= '0;
      dodge_cnt <= '0;
      atk_reset <= 1'b0;
      atk_start <= 1'b0;
      dodge_en  <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_ATK_RUN && atk_pass)
        dmg <= atk_damage;
      if (state == ST_APPLY)
        dodge_cnt <= '0;
      else if (state == ST_DODGE)
        dodge_cnt <= dodge_cnt + 16'd1;
      atk_reset <= (state_next == ST_ATK_ARM);
      atk_start <= (state_next == ST_ATK_RUN);
      dodge_en  <= (state_next == ST_DODGE);
      win       <= (state_next == ST_WIN);
      lose      <= (state_next == ST_LOSE);
    end
  end

endmodule

// File: tb/tb_battle_sequencer.sv
// Scoreboard bench for battle_sequencer: directed game scenarios followed by
// randomized play, checked every cycle against a behavioural game model.
module tb_battle_sequencer;

  localparam int ENEMY0 = 100;
  localparam int PLAYER0 = 20;
  localparam int HIT = 4;
  localparam int DODGE = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_game = 1'b0;
  logic       act_btn = 1'b0;
  logic       atk_pass = 1'b0;
  logic [7:0] atk_damage = '0;
  logic       player_hit = 1'b0;
  logic       atk_reset, atk_start, dodge_en, win, lose;
  logic [7:0] enemy_hp, player_hp;
  logic [2:0] phase;

  battle_sequencer #(
    .ENEMY_HP_INIT  (8'd100),
    .PLAYER_HP_INIT (8'd20),
    .HIT_DMG        (8'd4),
    .DODGE_CYCLES   (16'd1000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_game (start_game),
    .act_btn    (act_btn),
    .atk_pass   (atk_pass),
    .atk_damage (atk_damage),
    .player_hit (player_hit),
    .atk_reset  (atk_reset),
    .atk_start  (atk_start),
    .dodge_en   (dodge_en),
    .enemy_hp   (enemy_hp),
    .player_hp  (player_hp),
    .phase      (phase),
    .win        (win),
    .lose       (lose)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    ph;
    int    ehp;
    int    php;
    string tag;
  } exp_t;

  exp_t  expq[$];
  exp_t  e;
  int    checks = 0;
  int    passes = 0;
  int    pushed = 0;
  string cur_tag = "init";
  int    hit_at[$];

  // Game model: phase numbers are the renderer codes, dodge time counts down.
  int m_ph = 0, m_ehp = ENEMY0, m_php = PLAYER0, m_dmg = 0, m_left = 0;

  function automatic int clamp0(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic model(input bit r, s, a, p, input int d, input bit h);
    if (r) begin
      m_ph = 0; m_ehp = ENEMY0; m_php = PLAYER0; m_dmg = 0; m_left = 0;
    end else if (m_ph == 0) begin
      if (s) begin m_ph = 1; m_ehp = ENEMY0; m_php = PLAYER0; end
    end else if (m_ph == 1) begin
      if (a) m_ph = 2;
    end else if (m_ph == 2) begin
      m_ph = 3;
    end else if (m_ph == 3) begin
      if (p) begin m_dmg = d; m_ph = 4; end
    end else if (m_ph == 4) begin
      m_ehp = clamp0(m_ehp - m_dmg);
      if (m_ehp == 0) m_ph = 6;
      else begin m_ph = 5; m_left = DODGE; end
    end else if (m_ph == 5) begin
      if (h) m_php = clamp0(m_php - HIT);
      m_left = m_left - 1;
      if (m_php == 0) m_ph = 7;
      else if (m_left == 0) m_ph = 1;
    end else begin
      if (s) m_ph = 0;
    end
  endtask

  task automatic step(input bit r, s, a, p, input logic [7:0] d, input bit h);
    exp_t x;
    reset = r; start_game = s; act_btn = a; atk_pass = p; atk_damage = d; player_hit = h;
    model(r, s, a, p, int'(d), h);
    x.ph = m_ph; x.ehp = m_ehp; x.php = m_php; x.tag = cur_tag;
    expq.push_back(x);
    pushed++;
    @(posedge clk);
    #1;
  endtask

  task automatic attack(input logic [7:0] d);
    step(0, 0, 1, 0, 8'd0, 0);
    step(0, 0, 0, 1, d + 8'd7, 0);
    step(0, 0, 0, 1, d, 0);
    step(0, 0, 0, 0, 8'd0, 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bit h;
      h = 0;
      foreach (hit_at[k]) if (hit_at[k] == i) h = 1;
      step(0, 0, 0, 0, 8'd0, h);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      bit bad;
      e = expq.pop_front();
      bad = (int'(phase) != e.ph) || (int'(enemy_hp) != e.ehp) || (int'(player_hp) != e.php) ||
            (atk_reset != (e.ph == 2)) || (atk_start != (e.ph == 3)) ||
            (dodge_en != (e.ph == 5)) || (win != (e.ph == 6)) || (lose != (e.ph == 7));
      checks++;
      if (bad)
        $display("FAIL %s @%0t: got phase=%0d ehp=%0d php=%0d rst=%b st=%b dg=%b w=%b l=%b; want phase=%0d ehp=%0d php=%0d",
                 e.tag, $time, phase, enemy_hp, player_hp, atk_reset, atk_start, dodge_en, win, lose,
                 e.ph, e.ehp, e.php);
      else
        passes++;
    end
  end

  initial begin
    cur_tag = "reset";
    step(1, 0, 0, 0, 8'd0, 0);
    step(1, 1, 1, 1, 8'hff, 1);

    cur_tag = "start";
    step(0, 1, 0, 0, 8'd0, 0);
    cur_tag = "menu_hit";
    step(0, 0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 1);

    cur_tag = "attack20";
    attack(8'd20);
    cur_tag = "dodge_full";
    run(DODGE);
    cur_tag = "attack70";
    attack(8'd70);
    run(DODGE);
    cur_tag = "win_sat";
    attack(8'd20);
    step(0, 0, 1, 1, 8'd0, 1);
    cur_tag = "restart_win";
    step(0, 1, 0, 0, 8'd0, 0);
    step(0, 1, 0, 0, 8'd0, 0);

    cur_tag = "lose_last";
    attack(8'd5);
    hit_at = '{10, 20, 30, 40, 999};
    run(DODGE);
    hit_at = {};
    step(0, 0, 1, 0, 8'd0, 1);
    cur_tag = "restart_lose";
    step(0, 1, 0, 0, 8'd0, 0);
    step(0, 1, 0, 0, 8'd0, 0);

    cur_tag = "reset_dodge";
    attack(8'd30);
    run(500);
    step(1, 1, 0, 0, 8'd0, 1);
    step(0, 0, 0, 0, 8'd0, 0);

    cur_tag = "random";
    for (int i = 0; i < 15000; i++) begin
      bit r, s, a, p, h;
      logic [7:0] d;
      r = ($urandom_range(0, 2999) == 0);
      s = ($urandom_range(0, 19) == 0);
      a = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 7) == 0);
      h = ($urandom_range(0, 299) == 0);
      d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 255));
      step(r, s, a, p, d, h);
    end

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0 || pushed + 1 != checks)
      $display("FAIL drain: got %0d left, %0d compared; want 0 left, %0d compared",
               expq.size(), checks - 1, pushed);
    else
      passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/battle_sequencer.md
BATTLE_SEQUENCER -- requirements
Module: battle_sequencer

Interface
REQ-001 Parameter: ENEMY_HP_INIT, 100, enemy HP loaded at reset/new game.
REQ-002 Parameter: PLAYER_HP_INIT, 20, player HP loaded at reset/new game.
REQ-003 Parameter: HIT_DMG, 4, player HP lost per player_hit pulse.
REQ-004 Parameter: DODGE_CYCLES, 1000, dodge-phase length in clk cycles (16-bit counter).
REQ-005 Clocking and reset SHALL be: reset reset, synchronous, active-high; clock clk.
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 start_game  in  1  level; starts game from IDLE, restarts from WIN/LOSE.
REQ-009 act_btn  in  1  level; selects FIGHT in MENU.
REQ-010 atk_pass  in  1  attack-gauge done flag.
REQ-011 atk_damage  in  8  attack-gauge damage, valid while atk_pass=1.
REQ-012 player_hit  in  1  one-cycle pulse per bullet collision.
REQ-013 atk_reset  out  1  one-cycle clear to attack gauge.
REQ-014 atk_start  out  1  enables attack gauge.
REQ-015 dodge_en  out  1  enables bullet renderer/collision.
REQ-016 enemy_hp  out  8  current enemy HP.
REQ-017 player_hp  out  8  current player HP.
REQ-018 phase  out  3  current state encoding for renderer.
REQ-019 win / lose  out  1 each  terminal flags.

Function
REQ-020 States SHALL be IDLE=0, MENU=1, ATK_ARM=2, ATK_RUN=3, APPLY=4, DODGE=5, WIN=6, LOSE=7; phase SHALL equal state; all outputs registered.
REQ-021 IDLE: start_game=1 -> MENU next cycle, HPs reloaded to init values.
REQ-022 MENU: act_btn=1 -> ATK_ARM; otherwise hold.
REQ-023 ATK_ARM: exactly one cycle, atk_reset=1, atk_start=0, then ATK_RUN.
REQ-024 ATK_RUN: atk_start=1; atk_pass=1 (ignored in ATK_ARM) -> capture atk_damage into dmg register, go APPLY.
REQ-025 APPLY: one cycle; enemy_hp <= enemy_hp - dmg saturating at 0; next state WIN if result 0, else DODGE with dodge counter cleared.
REQ-026 DODGE: dodge_en=1; counter increments each cycle; each player_hit decrements player_hp by HIT_DMG saturating at 0.
REQ-027 DODGE exit: player_hp result 0 -> LOSE; else counter = DODGE_CYCLES-1 -> MENU; hit and expiry on same cycle: hit applied first, LOSE has priority.
REQ-028 player_hit outside DODGE SHALL be ignored.
REQ-029 WIN sets win=1, LOSE sets lose=1; both hold all HPs; start_game=1 -> IDLE, clears flag.
REQ-030 atk_start and dodge_en SHALL never be high simultaneously; atk_start=0 in every state except ATK_RUN.
REQ-031 Subtraction SHALL be 9-bit internal, clamp to 0 on borrow; no wrap-around.

Reset
REQ-032 reset=1 at any clock edge, any state: state=IDLE, enemy_hp=ENEMY_HP_INIT, player_hp=PLAYER_HP_INIT, dmg=0, counter=0, atk_reset=0, atk_start=0, dodge_en=0, win=0, lose=0, phase=0.
REQ-033 reset SHALL take priority over all inputs including start_game.

Structure
REQ-034 Package battle_pkg SHALL hold state encoding and default HP/damage constants shared with renderer and attack gauge.
REQ-035 One sub-module battle_hp_counter (load, saturating decrement, zero flag) SHALL be instantiated twice, for enemy and player HP.

Verification
REQ-036 Reset, start_game=1, act_btn=1 -> MENU, ATK_ARM with one-cycle atk_reset, ATK_RUN with atk_start=1.
REQ-037 In ATK_RUN, atk_pass=1, atk_damage=20 -> enemy_hp 100->80 after APPLY, then dodge_en=1 for exactly 1000 cycles, back to MENU.
REQ-038 enemy_hp=10, atk_damage=20 -> enemy_hp=0 (no wrap), win=1, phase=6.
REQ-039 player_hp=4, player_hit on final dodge cycle -> player_hp=0, lose=1, not MENU.
REQ-040 player_hit during MENU -> player_hp unchanged at 20.
REQ-041 reset asserted mid-DODGE -> next cycle IDLE, enemy_hp=100, player_hp=20, dodge_en=0.
